// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register serial link (transmit and receive sides).
package usr_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_serial_rx_if.sv
// Serial input and parallel output bundle of the serial receiver.
// Handshake: a word transfers on any clock edge where par_valid && par_ready;
// par_valid never drops without a transfer, and par_out is stable while par_valid is high.
interface usr_serial_rx_if #(parameter int SIZE = 4);

  logic            ser_in;
  logic            ser_valid;
  logic            ser_sof;
  logic            dir;
  logic [SIZE-1:0] par_out;
  logic            par_valid;
  logic            par_ready;
  logic            busy;
  logic            overflow;
  logic            frame_err;
  logic            err_clr;

  modport master (
    output ser_in, ser_valid, ser_sof, dir, par_ready, err_clr,
    input  par_out, par_valid, busy, overflow, frame_err
  );

  modport slave (
    input  ser_in, ser_valid, ser_sof, dir, par_ready, err_clr,
    output par_out, par_valid, busy, overflow, frame_err
  );

endinterface

// File: rtl/usr_rx_shreg.sv
// Receive shift register: shifts toward LSB (LSB-first) or toward MSB (MSB-first).
module usr_rx_shreg #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            bit_i,
  input  logic            dir_i,
  output logic [SIZE-1:0] word_o
);
  import usr_pkg::*;

  logic [SIZE-1:0] q_q;
  logic [SIZE-1:0] first_w;

  // word_o is the register contents with bit_i already shifted in, so the
  // completing bit can reach the output register on the same edge.
  assign word_o  = (dir_i == DIR_MSB_FIRST) ? {q_q[SIZE-2:0], bit_i}
                                            : {bit_i, q_q[SIZE-1:1]};
  assign first_w = (dir_i == DIR_MSB_FIRST) ? {{(SIZE-1){1'b0}}, bit_i}
                                            : {bit_i, {(SIZE-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en_i && clr_i) begin
      q_q <= first_w;
    end else if (en_i) begin
      q_q <= word_o;
    end else if (clr_i) begin
      q_q <= '0;
    end
  end

endmodule

// File: rtl/usr_serial_rx.sv
// Serial-to-parallel receiver: frame FSM, bit counter, one-deep output register, sticky errors.
module usr_serial_rx #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  usr_serial_rx_if.slave    bus
);
  import usr_pkg::*;

  localparam int CW = $clog2(SIZE + 1);

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [SIZE-1:0] par_out_q, par_out_d;
  logic            par_valid_q, par_valid_d;
  logic            ovf_q, ovf_d;
  logic            ferr_q, ferr_d;

  logic            start, complete, slot_free, ovf_set, ferr_set;
  logic            sh_en, sh_clr, sh_dir;
  logic [SIZE-1:0] sh_word;

  usr_rx_shreg #(.SIZE(SIZE)) u_shreg (
    .clk    (clk),
    .rst_n  (rst),
    .en_i   (sh_en),
    .clr_i  (sh_clr),
    .bit_i  (bus.ser_in),
    .dir_i  (sh_dir),
    .word_o (sh_word)
  );

  assign start     = bus.ser_valid && bus.ser_sof;
  assign slot_free = !par_valid_q || bus.par_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    sh_en    = 1'b0;
    sh_clr   = 1'b0;
    sh_dir   = dir_q;
    complete = 1'b0;
    ferr_set = 1'b0;
    // A start bit always begins a fresh frame; mid-frame it discards the partial word.
    if (start) begin
      ferr_set = (state_q == ST_RECV);
      state_d  = ST_RECV;
      cnt_d    = CW'(1);
      dir_d    = bus.dir;
      sh_dir   = bus.dir;
      sh_en    = 1'b1;
      sh_clr   = 1'b1;
    end else if (bus.ser_valid && (state_q == ST_RECV)) begin
      if (cnt_q == CW'(SIZE - 1)) begin
        complete = 1'b1;
        state_d  = ST_IDLE;
        cnt_d    = '0;
        sh_clr   = 1'b1;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        sh_en    = 1'b1;
      end
    end
  end

  always_comb begin
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    ovf_set     = 1'b0;
    if (complete) begin
      if (slot_free) begin
        par_out_d   = sh_word;
        par_valid_d = 1'b1;
      end else begin
        ovf_set     = 1'b1;
      end
    end else if (par_valid_q && bus.par_ready) begin
      par_valid_d = 1'b0;
    end
    ovf_d  = (ovf_q && !bus.err_clr) || ovf_set;
    ferr_d = (ferr_q && !bus.err_clr) || ferr_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_q       <= DIR_LSB_FIRST;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
  assign bus.busy      = (state_q == ST_RECV);
  assign bus.overflow  = ovf_q;
  assign bus.frame_err = ferr_q;

endmodule
